// File: rtl/mux_8ch.sv
// Registered 8-to-1 multiplexer over DATA_WIDTH-bit channels a..h.
// Optional MUX_SEL_CHANGE_EN adds a registered one-cycle selector-change flag.
module mux_8ch #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [2:0]            selector_i,
    input  logic [DATA_WIDTH-1:0] channel_a_i,
    input  logic [DATA_WIDTH-1:0] channel_b_i,
    input  logic [DATA_WIDTH-1:0] channel_c_i,
    input  logic [DATA_WIDTH-1:0] channel_d_i,
    input  logic [DATA_WIDTH-1:0] channel_e_i,
    input  logic [DATA_WIDTH-1:0] channel_f_i,
    input  logic [DATA_WIDTH-1:0] channel_g_i,
    input  logic [DATA_WIDTH-1:0] channel_h_i,
    output logic [DATA_WIDTH-1:0] channel_out_o
`ifdef MUX_SEL_CHANGE_EN
    ,
    output logic                  sel_changed_o
`endif
);

    // Array indexing lets an X/Z selector propagate X to the output in simulation.
    logic [DATA_WIDTH-1:0] channel [8];

    always_comb begin
        channel[0] = channel_a_i;
        channel[1] = channel_b_i;
        channel[2] = channel_c_i;
        channel[3] = channel_d_i;
        channel[4] = channel_e_i;
        channel[5] = channel_f_i;
        channel[6] = channel_g_i;
        channel[7] = channel_h_i;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            channel_out_o <= '0;
        end else begin
            channel_out_o <= channel[selector_i];
        end
    end

`ifdef MUX_SEL_CHANGE_EN
    logic [2:0] sel_prev;

    // The first sample after reset compares against the reset value 0.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sel_prev      <= 3'd0;
            sel_changed_o <= 1'b0;
        end else begin
            sel_prev      <= selector_i;
            sel_changed_o <= (selector_i != sel_prev);
        end
    end
`endif

endmodule

// File: tb/tb_mux_8ch.sv
// Directed self-checking bench for mux_8ch (32-bit and 8-bit instances).
// Exercises sel_changed_o as well when MUX_SEL_CHANGE_EN is defined.
module tb_mux_8ch;

    logic        clk_i;
    logic        arstn_i;
    logic [2:0]  selector_i;
    logic [31:0] ch_a, ch_b, ch_c, ch_d, ch_e, ch_f, ch_g, ch_h;
    logic [31:0] channel_out_o;

    logic [2:0]  sel8;
    logic [7:0]  ch8_a, ch8_b, ch8_c, ch8_d, ch8_e, ch8_f, ch8_g, ch8_h;
    logic [7:0]  out8;

    logic [31:0] exp_tab [8];

    int n_cmp = 0;
    int n_err = 0;

`ifdef MUX_SEL_CHANGE_EN
    logic sel_changed_o;
    logic sel_changed8;
`endif

    mux_8ch #(.DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .selector_i   (selector_i),
        .channel_a_i  (ch_a),
        .channel_b_i  (ch_b),
        .channel_c_i  (ch_c),
        .channel_d_i  (ch_d),
        .channel_e_i  (ch_e),
        .channel_f_i  (ch_f),
        .channel_g_i  (ch_g),
        .channel_h_i  (ch_h),
        .channel_out_o(channel_out_o)
`ifdef MUX_SEL_CHANGE_EN
        ,
        .sel_changed_o(sel_changed_o)
`endif
    );

    mux_8ch #(.DATA_WIDTH(8)) dut8 (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .selector_i   (sel8),
        .channel_a_i  (ch8_a),
        .channel_b_i  (ch8_b),
        .channel_c_i  (ch8_c),
        .channel_d_i  (ch8_d),
        .channel_e_i  (ch8_e),
        .channel_f_i  (ch8_f),
        .channel_g_i  (ch8_g),
        .channel_h_i  (ch8_h),
        .channel_out_o(out8)
`ifdef MUX_SEL_CHANGE_EN
        ,
        .sel_changed_o(sel_changed8)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        exp_tab[0] = 32'h12153524;
        exp_tab[1] = 32'hC0895E81;
        exp_tab[2] = 32'h8484D609;
        exp_tab[3] = 32'hB1F05663;
        exp_tab[4] = 32'h06B97B0D;
        exp_tab[5] = 32'h46DF998D;
        exp_tab[6] = 32'hB2C28465;
        exp_tab[7] = 32'h89375212;

        ch_a = exp_tab[0]; ch_b = exp_tab[1]; ch_c = exp_tab[2]; ch_d = exp_tab[3];
        ch_e = exp_tab[4]; ch_f = exp_tab[5]; ch_g = exp_tab[6]; ch_h = exp_tab[7];
        selector_i = 3'd2;
        ch8_a = 8'h11; ch8_b = 8'h22; ch8_c = 8'h33; ch8_d = 8'h44;
        ch8_e = 8'h55; ch8_f = 8'h66; ch8_g = 8'h77; ch8_h = 8'hA5;
        sel8 = 3'd7;
        arstn_i = 1'b0;

        // Reset with nonzero channels: output 0 and held across edges.
        #2;
        check_val("rst_async", channel_out_o, 32'h0);
        tick();
        tick();
        check_val("rst_held", channel_out_o, 32'h0);
        check_val("rst_held_w8", {24'h0, out8}, 32'h0);

        // Release between edges; first capture on next edge.
        #2 arstn_i = 1'b1;
        #1;
        check_val("release_no_capture", channel_out_o, 32'h0);

        // Channel sweep.
        for (int i = 0; i < 8; i++) begin
            selector_i = i[2:0];
            #1;
            if (i > 0) check_val("sweep_pre_edge", channel_out_o, exp_tab[i-1]);
            tick();
            check_val($sformatf("sweep_sel%0d", i), channel_out_o, exp_tab[i]);
        end

        // Width: 8-bit instance, sel 7 held since reset release.
        check_val("width8_h", {24'h0, out8}, 32'h000000A5);

        // Data-only change on channel d.
        selector_i = 3'd3;
        tick();
        check_val("sel3_base", channel_out_o, 32'hB1F05663);
        ch_d = 32'hDEADBEEF;
        #2;
        check_val("data_chg_not_before_edge", channel_out_o, 32'hB1F05663);
        tick();
        check_val("data_chg_after_edge", channel_out_o, 32'hDEADBEEF);
        ch_a = 32'h0BADF00D;
        tick();
        check_val("unselected_chg_ignored", channel_out_o, 32'hDEADBEEF);

        // Mid-operation reset.
        selector_i = 3'd5;
        tick();
        check_val("sel5_base", channel_out_o, 32'h46DF998D);
        #1 arstn_i = 1'b0;
        #1;
        check_val("mid_rst_async", channel_out_o, 32'h0);
        #1 arstn_i = 1'b1;
        #1;
        check_val("mid_rst_released_pre_edge", channel_out_o, 32'h0);
        tick();
        check_val("mid_rst_recover", channel_out_o, 32'h46DF998D);

        // 8-bit instance selection change.
        sel8 = 3'd2;
        tick();
        check_val("width8_c", {24'h0, out8}, 32'h00000033);

`ifdef MUX_SEL_CHANGE_EN
        begin
            logic [2:0] seq [5];
            logic       exp_chg [5];
            seq[0] = 3'd0; seq[1] = 3'd0; seq[2] = 3'd4; seq[3] = 3'd4; seq[4] = 3'd1;
            exp_chg[0] = 1'b0; exp_chg[1] = 1'b0; exp_chg[2] = 1'b1;
            exp_chg[3] = 1'b0; exp_chg[4] = 1'b1;
            #1 arstn_i = 1'b0;
            #1;
            check_val("selchg_rst", {31'h0, sel_changed_o}, 32'h0);
            arstn_i = 1'b1;
            for (int i = 0; i < 5; i++) begin
                selector_i = seq[i];
                tick();
                check_val($sformatf("selchg_step%0d", i), {31'h0, sel_changed_o},
                          {31'h0, exp_chg[i]});
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
